// File: rtl/avalon_mult_pkg.sv
// Shared definitions for the Avalon-MM multiplier responder.
//   - word addresses of the register map
//   - CTRL / STATUS bit positions
//   - legality check for the read-latency parameter
package avalon_mult_pkg;

  typedef logic [15:0] word_t;

  localparam logic [3:0] ADDR_A_LO   = 4'd0;
  localparam logic [3:0] ADDR_A_HI   = 4'd1;
  localparam logic [3:0] ADDR_B_LO   = 4'd2;
  localparam logic [3:0] ADDR_B_HI   = 4'd3;
  localparam logic [3:0] ADDR_RES0   = 4'd4;
  localparam logic [3:0] ADDR_RES1   = 4'd5;
  localparam logic [3:0] ADDR_RES2   = 4'd6;
  localparam logic [3:0] ADDR_RES3   = 4'd7;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, _rst   clock, asynchronous active-low reset
//   start       load a/b and begin (ignored while busy)
//   a, b        SZ-bit unsigned operands
//   busy        high from the cycle after start until completion
//   done_pulse  high during the final iteration cycle
//   product     full 2*SZ-bit product, valid while done_pulse=1
module seq_shift_add_mult #(
  parameter int unsigned SZ = 32
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic            start,
  input  logic [SZ-1:0]   a,
  input  logic [SZ-1:0]   b,
  output logic            busy,
  output logic            done_pulse,
  output logic [2*SZ-1:0] product
);

  localparam int unsigned CNT_W = $clog2(SZ);

  logic [2*SZ-1:0] r_mcand;
  logic [SZ-1:0]   r_mplier;
  logic [2*SZ-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic            r_busy;

  logic [2*SZ-1:0] w_acc_next;
  logic            w_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = r_busy && (r_cnt == CNT_W'(SZ - 1));

  // The final accumulation is exposed combinationally so the wrapper can
  // capture the product on the same edge that retires the last iteration.
  assign busy       = r_busy;
  assign done_pulse = w_last;
  assign product    = w_acc_next;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand  <= {{SZ{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/avalon_mm_mult_responder.sv
// Avalon-MM pipelined-read slave around a sequential 32x32 multiplier.
// Ports:
//   clk, _rst       clock, asynchronous active-low reset
//   address         word address (A_LO..B_HI, RES0..RES3, CTRL, STATUS)
//   read, write     command strobes; read wins when both are high
//   writedata       16-bit write data
//   waitrequest     combinational stall (operand/start writes while busy)
//   readdata        read data, held between valid pulses
//   readdatavalid   one pulse per accepted read, RD_LAT cycles later
//   irq             level interrupt mirroring the done bit
module avalon_mm_mult_responder
  import avalon_mult_pkg::*;
#(
  parameter int unsigned SZ     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic [15:0] readdata,
  output logic        readdatavalid,
  output logic        irq
);

  if (SZ != 32) begin : g_sz_check
    $error("avalon_mm_mult_responder: SZ must be 32");
  end
  if (!rd_lat_legal(RD_LAT)) begin : g_lat_check
    $error("avalon_mm_mult_responder: RD_LAT must be 1 or 2");
  end

  logic [SZ-1:0]   r_a;
  logic [SZ-1:0]   r_b;
  logic [2*SZ-1:0] r_res;
  logic            r_done;
  logic            r_err;

  logic [RD_LAT-1:0] r_vld;
  word_t             r_dat [RD_LAT];

  logic            w_busy;
  logic            w_done_pulse;
  logic [2*SZ-1:0] w_product;
  logic            w_rd_acc;
  logic            w_wr_acc;
  logic            w_collide;
  logic            w_start;
  logic            w_clr;
  word_t           w_rd_data;

  assign waitrequest = write && w_busy &&
                       ((address <= ADDR_B_HI) ||
                        ((address == ADDR_CTRL) && writedata[CTRL_START]));

  // A simultaneous read+write is handled as a read only; the write half
  // is dropped and flagged through the sticky err bit.
  assign w_rd_acc  = read && !waitrequest;
  assign w_wr_acc  = write && !read && !waitrequest;
  assign w_collide = read && write && !waitrequest;

  assign w_start = w_wr_acc && (address == ADDR_CTRL) && writedata[CTRL_START];
  assign w_clr   = w_wr_acc && (address == ADDR_CTRL) && !writedata[CTRL_START] &&
                   writedata[CTRL_CLR_DONE];

  seq_shift_add_mult #(
    .SZ(SZ)
  ) u_mult (
    .clk        (clk),
    ._rst       (_rst),
    .start      (w_start),
    .a          (r_a),
    .b          (r_b),
    .busy       (w_busy),
    .done_pulse (w_done_pulse),
    .product    (w_product)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_wr_acc) begin
      case (address)
        ADDR_A_LO: r_a[15:0]    <= writedata;
        ADDR_A_HI: r_a[SZ-1:16] <= writedata;
        ADDR_B_LO: r_b[15:0]    <= writedata;
        ADDR_B_HI: r_b[SZ-1:16] <= writedata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_res  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_done_pulse) begin
        r_res <= w_product;
      end
      // Completion outranks a clear_done landing in the same cycle so a
      // finished result is never silently lost.
      if (w_start) begin
        r_done <= 1'b0;
      end else if (w_done_pulse) begin
        r_done <= 1'b1;
      end else if (w_clr) begin
        r_done <= 1'b0;
      end
      if (w_collide) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (address)
      ADDR_A_LO:   w_rd_data = r_a[15:0];
      ADDR_A_HI:   w_rd_data = r_a[SZ-1:16];
      ADDR_B_LO:   w_rd_data = r_b[15:0];
      ADDR_B_HI:   w_rd_data = r_b[SZ-1:16];
      ADDR_RES0:   w_rd_data = r_res[15:0];
      ADDR_RES1:   w_rd_data = r_res[31:16];
      ADDR_RES2:   w_rd_data = r_res[47:32];
      ADDR_RES3:   w_rd_data = r_res[63:48];
      ADDR_STATUS: begin
        w_rd_data[STAT_BUSY] = w_busy;
        w_rd_data[STAT_DONE] = r_done;
        w_rd_data[STAT_ERR]  = r_err;
      end
      default:     w_rd_data = '0;
    endcase
  end

  // Each data stage only loads behind a valid, so the last stage naturally
  // holds its previous value between pulses.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= w_rd_data;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign readdatavalid = r_vld[RD_LAT-1];
  assign readdata      = r_dat[RD_LAT-1];
  assign irq           = r_done;

endmodule

// File: tb/tb_avalon_mm_mult_responder.sv
module tb_avalon_mm_mult_responder;

  localparam int SZ     = 32;
  localparam int RD_LAT = 2;

  logic        clk;
  logic        _rst;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [15:0] writedata;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        irq;

  avalon_mm_mult_responder #(
    .SZ     (SZ),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk           (clk),
    ._rst          (_rst),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] last_rd = '0;
  bit          mon_en  = 1'b0;

  // Reference model of the register file.
  logic [31:0] mA, mB;
  logic [63:0] mres, mpend;
  bit          mpending, mdone, merr;
  int          mstart;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void mreset();
    mA = '0; mB = '0; mres = '0; mpend = '0;
    mpending = 1'b0; mdone = 1'b0; merr = 1'b0; mstart = -1000;
  endfunction

  // Completion lands at edge mstart+SZ; visible to commands accepted later.
  function automatic void msync(input int n);
    if (mpending && n > mstart + SZ) begin
      mres = mpend; mdone = 1'b1; mpending = 1'b0;
    end
  endfunction

  function automatic logic [15:0] mread(input logic [3:0] a);
    logic [15:0] v;
    case (a)
      4'd0: v = mA[15:0];
      4'd1: v = mA[31:16];
      4'd2: v = mB[15:0];
      4'd3: v = mB[31:16];
      4'd4: v = mres[15:0];
      4'd5: v = mres[31:16];
      4'd6: v = mres[47:32];
      4'd7: v = mres[63:48];
      4'd9: v = {13'd0, merr, mdone, mpending};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic void mwrite(input logic [3:0] a, input logic [15:0] d, input int n);
    msync(n);
    case (a)
      4'd0: mA[15:0]  = d;
      4'd1: mA[31:16] = d;
      4'd2: mB[15:0]  = d;
      4'd3: mB[31:16] = d;
      4'd8: begin
        if (d[0]) begin
          mpend = 64'(mA) * 64'(mB);
          mpending = 1'b1; mstart = n; mdone = 1'b0;
        end else if (d[1]) begin
          mdone = 1'b0;
        end
      end
      default: ;
    endcase
  endfunction

  // Read-response scoreboard: checks data, order and exact arrival cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (readdatavalid) begin
        if (q.size() == 0) begin
          chk("rdv_unexpected", readdatavalid, 1'b0);
        end else begin
          mon_e = q.pop_front();
          chk("rd_data", readdata, mon_e.data);
          chk("rd_cycle", cyc, mon_e.due);
        end
        last_rd = readdata;
      end else begin
        chk("rd_hold", readdata, last_rd);
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("rdv_missing", readdatavalid, 1'b1);
          void'(q.pop_front());
        end
      end
    end
  end

  // All bus tasks start and end at posedge+1.
  task automatic rd_exp(input logic [3:0] a, input logic [15:0] e);
    address = a; read = 1'b1; write = 1'b0;
    @(negedge clk);
    chk("rd_waitrequest", waitrequest, 1'b0);
    msync(cyc + 1);
    q.push_back('{data: e, due: cyc + RD_LAT});
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic rd_model(input logic [3:0] a);
    address = a; read = 1'b1; write = 1'b0;
    @(negedge clk);
    chk("rd_waitrequest", waitrequest, 1'b0);
    msync(cyc + 1);
    q.push_back('{data: mread(a), due: cyc + RD_LAT});
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, output int acc, output int stalls);
    address = a; writedata = d; write = 1'b1; read = 1'b0; stalls = 0;
    @(negedge clk);
    while (waitrequest === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL wr_timeout: waitrequest still 1 after %0d cycles, required 0", stalls);
    end
    acc = cyc + 1;
    mwrite(a, d, acc);
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic w(input logic [3:0] a, input logic [15:0] d);
    int acc, st;
    wr(a, d, acc, st);
  endtask

  task automatic rw(input logic [3:0] a, input logic [15:0] d);
    address = a; writedata = d; read = 1'b1; write = 1'b1;
    @(negedge clk);
    chk("rw_waitrequest", waitrequest, 1'b0);
    msync(cyc + 1);
    q.push_back('{data: mread(a), due: cyc + RD_LAT});
    merr = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (irq !== 1'b1 && n < max) begin
      n++;
      @(negedge clk);
    end
    chk("irq_wait", irq, 1'b1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[$];

  initial begin
    int s, acc, st;

    _rst = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    mreset();
    #2;
    chk("rst_rdv", readdatavalid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_readdata", readdata, 16'h0000);
    chk("rst_waitrequest", waitrequest, 1'b0);
    @(negedge clk); _rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    rd_model(4'd9);

    // Register map: operand readback, RO/unused regions, alias checks.
    vt.push_back('{1'b1, 4'd0,  16'h1111, 16'h0000});
    vt.push_back('{1'b1, 4'd1,  16'h2222, 16'h0000});
    vt.push_back('{1'b1, 4'd2,  16'h3333, 16'h0000});
    vt.push_back('{1'b1, 4'd3,  16'h4444, 16'h0000});
    vt.push_back('{1'b0, 4'd0,  16'h0000, 16'h1111});
    vt.push_back('{1'b0, 4'd1,  16'h0000, 16'h2222});
    vt.push_back('{1'b0, 4'd2,  16'h0000, 16'h3333});
    vt.push_back('{1'b0, 4'd3,  16'h0000, 16'h4444});
    vt.push_back('{1'b1, 4'd10, 16'hDEAD, 16'h0000});
    vt.push_back('{1'b1, 4'd15, 16'hBEEF, 16'h0000});
    vt.push_back('{1'b0, 4'd0,  16'h0000, 16'h1111});
    vt.push_back('{1'b0, 4'd3,  16'h0000, 16'h4444});
    vt.push_back('{1'b0, 4'd10, 16'h0000, 16'h0000});
    vt.push_back('{1'b0, 4'd15, 16'h0000, 16'h0000});
    vt.push_back('{1'b1, 4'd4,  16'hBEEF, 16'h0000});
    vt.push_back('{1'b0, 4'd4,  16'h0000, 16'h0000});
    vt.push_back('{1'b0, 4'd8,  16'h0000, 16'h0000});
    vt.push_back('{1'b0, 4'd9,  16'h0000, 16'h0000});
    vt.push_back('{1'b1, 4'd1,  16'h5A5A, 16'h0000});
    vt.push_back('{1'b0, 4'd1,  16'h0000, 16'h5A5A});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].is_wr) w(vt[i].a, vt[i].d);
      else             rd_exp(vt[i].a, vt[i].exp);
    end

    // Basic multiply, STATUS polled every cycle through completion.
    w(4'd0, 16'h0003); w(4'd1, 16'h0000); w(4'd2, 16'h0005); w(4'd3, 16'h0000);
    wr(4'd8, 16'h0001, s, st);
    chk("start_stall", st, 0);
    chk("irq_busy", irq, 1'b0);
    for (int i = 0; i < SZ + 3; i++) rd_model(4'd9);
    chk("irq_done", irq, 1'b1);
    rd_exp(4'd4, 16'h000F); rd_exp(4'd5, 16'h0000);
    rd_exp(4'd6, 16'h0000); rd_exp(4'd7, 16'h0000);

    // Maximum operands; RES read while busy returns previous result.
    w(4'd0, 16'hFFFF); w(4'd1, 16'hFFFF); w(4'd2, 16'hFFFF); w(4'd3, 16'hFFFF);
    wr(4'd8, 16'h0001, s, st);
    rd_exp(4'd4, 16'h000F);
    wait_irq(SZ + 5);
    rd_exp(4'd4, 16'h0001); rd_exp(4'd5, 16'h0000);
    rd_exp(4'd6, 16'hFFFE); rd_exp(4'd7, 16'hFFFF);
    w(4'd8, 16'h0002);
    chk("irq_cleared", irq, 1'b0);
    rd_exp(4'd9, 16'h0000);

    // Operand write stalled until busy falls; result uses the old A.
    w(4'd0, 16'h0007); w(4'd1, 16'h0000); w(4'd2, 16'h0009); w(4'd3, 16'h0000);
    wr(4'd8, 16'h0001, s, st);
    wr(4'd0, 16'h1234, acc, st);
    chk("stall_cycles", st, SZ);
    chk("stall_accept_edge", acc - s, SZ + 1);
    rd_exp(4'd4, 16'h003F); rd_exp(4'd5, 16'h0000);
    rd_exp(4'd0, 16'h1234);

    // clear_done alone never stalls; a start while busy does.
    wr(4'd8, 16'h0001, s, st);
    wr(4'd8, 16'h0002, acc, st);
    chk("clr_busy_stall", st, 0);
    wr(4'd8, 16'h0001, acc, st);
    chk("restart_accept_edge", acc - s, SZ + 1);
    rd_exp(4'd4, 16'hA3D4);
    wait_irq(SZ + 5);
    rd_exp(4'd4, 16'hA3D4); rd_exp(4'd5, 16'h0000);
    rd_exp(4'd6, 16'h0000); rd_exp(4'd7, 16'h0000);

    // Simultaneous read and write: read served, write dropped, err sticky.
    rw(4'd0, 16'hBEEF);
    rd_exp(4'd0, 16'h1234);
    rd_exp(4'd9, 16'h0006);

    // Reset mid-operation with a read response on the bus.
    wr(4'd8, 16'h0001, s, st);
    idle(8);
    mon_en = 1'b0;
    address = 4'd9; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    for (int k = 0; k < 5 && readdatavalid !== 1'b1; k++) @(negedge clk);
    chk("pre_rst_rdv", readdatavalid, 1'b1);
    chk("pre_rst_status", readdata, 16'h0005);
    address = 4'd0; writedata = 16'h0000; write = 1'b1;
    #1;
    chk("pre_rst_stall", waitrequest, 1'b1);
    _rst = 1'b0;
    #1;
    chk("mid_rst_rdv", readdatavalid, 1'b0);
    chk("mid_rst_irq", irq, 1'b0);
    chk("mid_rst_readdata", readdata, 16'h0000);
    chk("mid_rst_busy", waitrequest, 1'b0);
    write = 1'b0;
    mreset();
    q.delete();
    last_rd = '0;
    @(negedge clk); _rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    rd_exp(4'd4, 16'h0000); rd_exp(4'd5, 16'h0000);
    rd_exp(4'd6, 16'h0000); rd_exp(4'd7, 16'h0000);
    rd_exp(4'd9, 16'h0000); rd_exp(4'd0, 16'h0000);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL rd_drain: %0d responses outstanding, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
